mux3_rr_arbiter: RTL

- Round-robin arbiter that shares the mux3_1 3:1 datapath between three requesters.
- Requester i drives data bit in[i] and request req[i]. The arbiter generates one-hot grants and the matching mux3_1 select code.
- Instantiates mux3_1 internally; the arbitrated bit appears on out.
- Sits between the requesting agents and any single-bit shared consumer.

---
 rtl/mux3_rr_arbiter_if.sv | 29 ++
 rtl/mux3_rr_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mux3_rr_arbiter_if.sv
// Handshake/data bundle between three requesters and mux3_rr_arbiter.
// The lock signal exists only when MUX3_ARB_LOCK_EN is defined.
interface mux3_rr_arbiter_if;
    logic [2:0] req;
    logic [2:0] in;
    logic [2:0] gnt;
    logic [1:0] select;
    logic       busy;
    logic       out;
`ifdef MUX3_ARB_LOCK_EN
    logic       lock;
`endif

    modport slave (
        input  req, in,
`ifdef MUX3_ARB_LOCK_EN
        input  lock,
`endif
        output gnt, select, busy, out
    );

    modport master (
        output req, in,
`ifdef MUX3_ARB_LOCK_EN
        output lock,
`endif
        input  gnt, select, busy, out
    );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing a mux3_1 datapath between three requesters.
// Optional MUX3_ARB_LOCK_EN adds a lock input that suppresses hold-limit preemption.
module mux3_1 (
    input  logic [2:0] in,
    input  logic [1:0] select,
    output logic       out
);
    // 00 is never driven while a grant is active, so its output value is arbitrary
    always_comb begin
        out = 1'b0;
        case (select)
            2'b01:   out = in[2];
            2'b10:   out = in[1];
            2'b11:   out = in[0];
            default: out = 1'b0;
        endcase
    end
endmodule

module mux3_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux3_rr_arbiter_if.slave   bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_n;
    logic [1:0]       owner, owner_n;
    logic [1:0]       ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       gnt_q, gnt_n;
    logic [1:0]       sel_q, sel_n;
    logic             busy_q, busy_n;
    logic             lock_on;

`ifdef MUX3_ARB_LOCK_EN
    assign lock_on = bus.lock;
`else
    assign lock_on = 1'b0;
`endif

    function automatic logic [1:0] nxt(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // First set bit of r scanning upward from p, wrapping mod 3
    function automatic pick_t pick(input logic [2:0] r, input logic [1:0] p);
        pick_t      res;
        logic [1:0] i;
        res = '0;
        i   = p;
        for (int n = 0; n < 3; n++) begin
            if (!res.found && r[i]) begin
                res.found = 1'b1;
                res.idx   = i;
            end
            i = nxt(i);
        end
        return res;
    endfunction

    function automatic logic [1:0] enc(input logic [1:0] idx);
        return 2'd3 - idx;
    endfunction

    always_comb begin
        pick_t      p;
        logic [2:0] others;
        logic       at_max;
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt_q;
        sel_n   = sel_q;
        busy_n  = busy_q;
        p       = '0;
        others  = bus.req & ~(3'b001 << owner);
        at_max  = (cnt == HOLD_MAX);

        case (state)
            IDLE: begin
                p = pick(bus.req, ptr);
                if (p.found) begin
                    state_n = GRANT;
                    owner_n = p.idx;
                    cnt_n   = CNT_ONE;
                    gnt_n   = 3'b001 << p.idx;
                    sel_n   = enc(p.idx);
                    busy_n  = 1'b1;
                end
            end
            GRANT: begin
                if (bus.req[owner] && !(at_max && (others != 3'b000) && !lock_on)) begin
                    // Keep: restart the window for a lone owner, saturate under lock
                    if (!at_max)
                        cnt_n = cnt + CNT_ONE;
                    else if (lock_on)
                        cnt_n = HOLD_MAX;
                    else
                        cnt_n = CNT_ONE;
                end else begin
                    ptr_n = nxt(owner);
                    p     = pick(others, nxt(owner));
                    if (p.found) begin
                        owner_n = p.idx;
                        cnt_n   = CNT_ONE;
                        gnt_n   = 3'b001 << p.idx;
                        sel_n   = enc(p.idx);
                        busy_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        gnt_n   = 3'b000;
                        sel_n   = 2'b00;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 3'b000;
                sel_n   = 2'b00;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= 2'd0;
            ptr    <= 2'd0;
            cnt    <= '0;
            gnt_q  <= 3'b000;
            sel_q  <= 2'b00;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            gnt_q  <= gnt_n;
            sel_q  <= sel_n;
            busy_q <= busy_n;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.select = sel_q;
    assign bus.busy   = busy_q;

    mux3_1 u_mux (
        .in     (bus.in),
        .select (sel_q),
        .out    (bus.out)
    );
endmodule
